// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a variable-latency imem bus and splits fields.
// Optional perf counters (retired_cnt, stall_cnt) are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    imem,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            inst_done,
    input  logic [1:0]      pcsel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            fault,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     stall_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] inst_q, inst_nxt;
    logic [XLEN-1:0] target;
    logic            retire;

    always_comb begin
        target = pc_q + XLEN'(4);
        case (pcsel)
            2'b00:   target = pc_q + XLEN'(4);
            2'b01:   target = pc_q + imm;
            2'b10:   target = {alu_result[XLEN-1:1], 1'b0};
            default: target = pc_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        inst_nxt  = inst_q;
        retire    = 1'b0;
        imem.req  = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    inst_nxt  = imem.rdata;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (inst_done) begin
                    // A misaligned target traps without moving the PC, so the offender stays visible.
                    if (target[1:0] != 2'b00) begin
                        state_nxt = FAULT;
                    end else begin
                        pc_nxt    = target;
                        retire    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            default: state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC[XLEN-1:0];
            inst_q <= '0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            inst_q <= inst_nxt;
        end
    end

    assign imem.addr  = pc_q;
    assign inst_valid = (state == VALID);
    assign fault      = (state == FAULT);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + XLEN'(4);
    assign op         = inst_q[6:0];
    assign rd         = inst_q[11:7];
    assign func3      = inst_q[14:12];
    assign rs1        = inst_q[19:15];
    assign rs2        = inst_q[24:20];
    assign func7      = inst_q[31:25];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire)
                retired_q <= retired_q + 32'd1;
            if (state == REQ && !imem.ack)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    assign retired_cnt = 32'd0;
    assign stall_cnt   = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; counter expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, fault;
    logic [31:0] inst, pc, pc_plus4, imm, alu_result, retired_cnt, stall_cnt;
    logic [6:0]  op, func7;
    logic [2:0]  func3;
    logic [4:0]  rd, rs1, rs2;
    logic        inst_done;
    logic [1:0]  pcsel;
    int          nvec = 0;
    int          nerr = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_unit_if #(.XLEN(32)) imem ();

    fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .inst_valid(inst_valid), .inst(inst), .op(op), .func3(func3), .func7(func7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .pc_plus4(pc_plus4),
        .inst_done(inst_done), .pcsel(pcsel), .imm(imm), .alu_result(alu_result),
        .fault(fault), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pexp(input logic [31:0] v);
        return PERF ? v : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retire_with(input logic [1:0] sel, input logic [31:0] im, input logic [31:0] alu);
        inst_done = 1'b1; pcsel = sel; imm = im; alu_result = alu;
        tick();
        inst_done = 1'b0; pcsel = 2'b00; imm = 32'hDEAD_0001; alu_result = 32'hDEAD_0003;
    endtask

    task automatic ack_with(input logic [31:0] word);
        imem.ack = 1'b1; imem.rdata = word;
        tick();
        imem.ack = 1'b0; imem.rdata = 32'hBAD0_BAD0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        nvec++; if (imem.req !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", imem.req); end
        nvec++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", inst_valid); end
        nvec++; if (inst !== 32'h0) begin nerr++; $display("FAIL rst_inst got %h want 0", inst); end
        nvec++; if (pc !== 32'h0) begin nerr++; $display("FAIL rst_pc got %h want 0", pc); end
        nvec++; if (fault !== 1'b0) begin nerr++; $display("FAIL rst_fault got %b want 0", fault); end
        nvec++; if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin nerr++; $display("FAIL rst_cnt got %0d/%0d want 0/0", retired_cnt, stall_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_fetch();
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin nerr++; $display("FAIL first_req got %b@%h want 1@0", imem.req, imem.addr); end
        ack_with(32'h0050_0093);
        nvec++; if (inst_valid !== 1'b1) begin nerr++; $display("FAIL first_valid got %b want 1", inst_valid); end
        nvec++; if (inst !== 32'h0050_0093) begin nerr++; $display("FAIL first_inst got %h want 00500093", inst); end
        nvec++; if (op !== 7'b0010011 || rd !== 5'd1 || rs1 !== 5'd0 || func3 !== 3'd0) begin nerr++; $display("FAIL first_fields got op=%b rd=%0d rs1=%0d f3=%0d want 0010011/1/0/0", op, rd, rs1, func3); end
        nvec++; if (rs2 !== 5'd5 || func7 !== 7'd0) begin nerr++; $display("FAIL first_rs2f7 got %0d/%0d want 5/0", rs2, func7); end
        nvec++; if (imem.req !== 1'b0 || pc_plus4 !== 32'h4) begin nerr++; $display("FAIL first_idle got req=%b pc4=%h want 0/4", imem.req, pc_plus4); end
    endtask

    task automatic test_sequential_wait();
        retire_with(2'b00, 32'h0, 32'h0);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin nerr++; $display("FAIL seq_req got %b@%h want 1@4", imem.req, imem.addr); end
        nvec++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL seq_valid got %b want 0", inst_valid); end
        nvec++; if (retired_cnt !== pexp(1)) begin nerr++; $display("FAIL seq_retired got %0d want %0d", retired_cnt, pexp(1)); end
        tick();
        retire_with(2'b01, 32'h100, 32'h0);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin nerr++; $display("FAIL req_done_ignored got %b@%h want 1@4", imem.req, imem.addr); end
        nvec++; if (stall_cnt !== pexp(2)) begin nerr++; $display("FAIL stall_mid got %0d want %0d", stall_cnt, pexp(2)); end
        tick();
        nvec++; if (stall_cnt !== pexp(3)) begin nerr++; $display("FAIL stall_3 got %0d want %0d", stall_cnt, pexp(3)); end
        ack_with(32'h40B5_0533);
        nvec++; if (inst_valid !== 1'b1 || inst !== 32'h40B5_0533) begin nerr++; $display("FAIL seq_inst got %b/%h want 1/40b50533", inst_valid, inst); end
        nvec++; if (op !== 7'h33 || rd !== 5'd10 || rs1 !== 5'd10 || rs2 !== 5'd11 || func7 !== 7'h20 || func3 !== 3'd0) begin nerr++; $display("FAIL seq_fields got op=%h rd=%0d rs1=%0d rs2=%0d f7=%h f3=%0d", op, rd, rs1, rs2, func7, func3); end
        nvec++; if (stall_cnt !== pexp(3) || pc !== 32'h4) begin nerr++; $display("FAIL seq_after got stall=%0d pc=%h want %0d/4", stall_cnt, pc, pexp(3)); end
    endtask

    task automatic test_branch_wrap();
        retire_with(2'b01, 32'hFFFF_FFF4, 32'h0);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFF8) begin nerr++; $display("FAIL br_neg got %b@%h want 1@fffffff8", imem.req, imem.addr); end
        ack_with(32'h0000_0013);
        nvec++; if (pc_plus4 !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL br_pc4 got %h want fffffffc", pc_plus4); end
        retire_with(2'b01, 32'h10, 32'h0);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h8) begin nerr++; $display("FAIL br_wrap got %b@%h want 1@8", imem.req, imem.addr); end
        nvec++; if (pc_plus4 !== 32'hC) begin nerr++; $display("FAIL br_wrap_pc4 got %h want c", pc_plus4); end
    endtask

    task automatic test_hold_and_ignores();
        ack_with(32'h0000_0013);
        retire_with(2'b01, 32'h38, 32'h0);
        nvec++; if (imem.addr !== 32'h40) begin nerr++; $display("FAIL hold_jump got %h want 40", imem.addr); end
        ack_with(32'h0000_0013);
        ack_with(32'hFFFF_FFFF);
        nvec++; if (inst !== 32'h13 || inst_valid !== 1'b1 || imem.req !== 1'b0) begin nerr++; $display("FAIL stray_ack got inst=%h v=%b req=%b want 13/1/0", inst, inst_valid, imem.req); end
        retire_with(2'b11, 32'h0, 32'h0);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h40 || inst_valid !== 1'b0) begin nerr++; $display("FAIL hold_refetch got %b@%h v=%b want 1@40 v=0", imem.req, imem.addr, inst_valid); end
        nvec++; if (retired_cnt !== pexp(5)) begin nerr++; $display("FAIL hold_retired got %0d want %0d", retired_cnt, pexp(5)); end
    endtask

    task automatic test_jalr();
        ack_with(32'h0000_0013);
        retire_with(2'b10, 32'h0, 32'h0000_0105);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h104) begin nerr++; $display("FAIL jalr_ok got %b@%h want 1@104", imem.req, imem.addr); end
        ack_with(32'h0000_0013);
        retire_with(2'b10, 32'h0, 32'h0000_0106);
        nvec++; if (fault !== 1'b1 || imem.req !== 1'b0 || inst_valid !== 1'b0) begin nerr++; $display("FAIL jalr_fault got f=%b req=%b v=%b want 1/0/0", fault, imem.req, inst_valid); end
        nvec++; if (pc !== 32'h104) begin nerr++; $display("FAIL fault_pc got %h want 104", pc); end
        nvec++; if (retired_cnt !== pexp(6)) begin nerr++; $display("FAIL fault_retired got %0d want %0d", retired_cnt, pexp(6)); end
        imem.ack = 1'b1; inst_done = 1'b1; pcsel = 2'b00;
        repeat (2) tick();
        imem.ack = 1'b0; inst_done = 1'b0;
        nvec++; if (fault !== 1'b1 || imem.req !== 1'b0 || pc !== 32'h104) begin nerr++; $display("FAIL fault_sticky got f=%b req=%b pc=%h want 1/0/104", fault, imem.req, pc); end
    endtask

    task automatic test_reset_mid_request();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++; if (fault !== 1'b0 || pc !== 32'h0 || imem.req !== 1'b0) begin nerr++; $display("FAIL rst_fault_clr got f=%b pc=%h req=%b want 0/0/0", fault, pc, imem.req); end
        tick();
        nvec++; if (imem.req !== 1'b1) begin nerr++; $display("FAIL rst_refetch got %b want 1", imem.req); end
        rst = 1'b1; imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; imem.ack = 1'b0;
        nvec++; if (inst_valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin nerr++; $display("FAIL mid_rst got v=%b inst=%h pc=%h want 0/0/0", inst_valid, inst, pc); end
        nvec++; if (imem.req !== 1'b0 || retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin nerr++; $display("FAIL mid_rst_idle got req=%b cnt=%0d/%0d want 0 0/0", imem.req, retired_cnt, stall_cnt); end
        tick();
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h0 || inst_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_restart got %b@%h v=%b want 1@0 v=0", imem.req, imem.addr, inst_valid); end
    endtask

    initial begin
        rst = 1'b1; inst_done = 1'b0; pcsel = 2'b00; imm = '0; alu_result = '0;
        imem.ack = 1'b0; imem.rdata = '0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_sequential_wait();
        test_branch_wrap();
        test_hold_and_ignores();
        test_jalr();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle decode controller.
- Owns the PC and fetches 32-bit instructions over a variable-latency req/ack instruction-memory port.
- Holds each fetched instruction stable and splits it into op/func3/func7/register fields for the controller.
- When the execute side retires the instruction, selects the next PC from the controller's 2-bit pcsel.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width (only 32 supported).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request, held high until acknowledged.
- imem_addr  output  XLEN  fetch address, equals pc while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  XLEN  instruction word.
- inst_valid  output  1  inst and decoded fields valid.
- inst  output  XLEN  registered instruction.
- op  output  7  inst[6:0].
- func3  output  3  inst[14:12].
- func7  output  7  inst[31:25].
- rd  output  5  inst[11:7].
- rs1  output  5  inst[19:15].
- rs2  output  5  inst[24:20].
- pc  output  XLEN  address of current instruction.
- pc_plus4  output  XLEN  pc+4, mod 2^32.
- inst_done  input  1  execute stage retires current instruction; pcsel/imm/alu_result sampled.
- pcsel  input  2  00 next, 01 jal/branch, 10 jalr, 11 hold.
- imm  input  XLEN  extended immediate.
- alu_result  input  XLEN  jalr target source.
- fault  output  1  misaligned target trap, sticky.
- retired_cnt  output  32  retired instruction count (optional feature).
- stall_cnt  output  32  cycles waiting on imem_ack (optional feature).

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-request):
  - pc=RESET_PC; state=IDLE.
  - inst=0, inst_valid=0, imem_req=0, fault=0, counters=0.
  - A pending ack is discarded.
- States: IDLE, REQ, VALID, FAULT.
- IDLE: next cycle goes to REQ unconditionally (one bubble after reset).
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: inst<=imem_rdata; state goes to VALID; inst_valid=1 from the next cycle.
  - Minimum latency: ack in the first REQ cycle puts the instruction valid 1 cycle after the request is raised.
- VALID:
  - inst, fields and pc are stable; imem_req=0.
  - On inst_done, compute the target:
    - 00: pc+4.
    - 01: pc+imm.
    - 10: {alu_result[31:1],1'b0}.
    - 11: pc (re-fetch the same address).
  - All additions wrap mod 2^32.
  - If target[1:0]!=0: state goes to FAULT, pc unchanged.
  - Otherwise pc<=target, inst_valid<=0, state goes to REQ.
  - inst_done=0 holds VALID indefinitely.
- FAULT: fault=1, inst_valid=0, imem_req=0; exit only via rst.
- Ignored inputs:
  - imem_ack outside REQ is ignored.
  - inst_done outside VALID is ignored.
  - imm and alu_result are don't-care unless inst_done=1 in VALID.
- pc_plus4 is combinational from pc.
- Decoded fields are combinational slices of the inst register.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - retired_cnt increments on each accepted inst_done in VALID, including pcsel=11 and excluding faulting retires.
  - stall_cnt increments on every REQ cycle with imem_ack=0.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset-then-run: RESET_PC=0, ack in the same cycle as req with rdata=32'h00500093 -> imem_addr=0; next cycle inst_valid=1, op=7'b0010011, rd=1, rs1=0, func3=0.
- Sequential plus wait states: ack delayed 3 cycles, inst_done with pcsel=00 -> next imem_addr=4; stall_cnt=3 (macro on).
- Branch wrap: pc=32'hFFFF_FFF8, pcsel=01, imm=32'h10 -> next imem_addr=32'h0000_0008.
- Jalr: pcsel=10, alu_result=32'h0000_0105 -> next imem_addr=32'h0000_0104; alu_result=32'h0000_0106 -> fault=1, imem_req stays 0, pc unchanged.
- Hold and ignores: pcsel=11 at pc=32'h40 -> re-fetch at 32'h40 and retired_cnt increments; stray imem_ack while VALID, and inst_done=1 while REQ -> no state change.
- Reset mid-request: rst asserted during REQ with ack arriving in the same cycle -> inst_valid=0, pc=RESET_PC, captured data discarded, fetch restarts after one IDLE cycle.
